branch_resolve_unit: RTL

EX-stage consumer of the branch comparator's br_eq/br_lt flags.
- Drives cmpop back to the comparator.
- Decodes funct3 into a taken/not-taken decision.
- Computes targets for branches, JAL and JALR.
- Runs a registered redirect handshake to fetch, plus one-cycle IF/ID and ID/EX flush pulses.
- Static predict-not-taken front end, so every taken control transfer redirects.

---
 rtl/branch_resolve_unit_if.sv | 21 ++
 rtl/branch_resolve_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit_if.sv
// Redirect handshake between the EX-stage branch resolve unit and fetch.
// Master drives the redirect request; slave (fetch) returns ready.
interface branch_resolve_unit_if #(
   parameter int unsigned WID_DATA = 32
);
   logic                redirect_valid;
   logic [WID_DATA-1:0] redirect_pc;
   logic                redirect_ready;

   modport master (
      output redirect_valid,
      output redirect_pc,
      input  redirect_ready
   );

   modport slave (
      input  redirect_valid,
      input  redirect_pc,
      output redirect_ready
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolution: taken decision, target, redirect handshake and flushes.
// Optional performance counters are enabled with macro BRU_PERF_CNT_EN.
module branch_resolve_unit #(
   parameter int unsigned         WID_DATA = 32,
   parameter logic [WID_DATA-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ex_valid,
   input  logic                  ex_is_branch,
   input  logic                  ex_is_jal,
   input  logic                  ex_is_jalr,
   input  logic [2:0]            ex_funct3,
   input  logic [WID_DATA-1:0]   ex_pc,
   input  logic [WID_DATA-1:0]   ex_imm,
   input  logic [WID_DATA-1:0]   rs1_data,
   input  logic                  br_eq,
   input  logic                  br_lt,
   output logic                  cmpop,
   output logic [WID_DATA-1:0]   link_data,
   branch_resolve_unit_if.master redir,
   output logic                  flush_if_id,
   output logic                  flush_id_ex,
   output logic                  stall_ex,
   output logic                  misalign_exc,
   output logic                  illegal_br
`ifdef BRU_PERF_CNT_EN
   ,
   output logic [31:0]           perf_branch_cnt,
   output logic [31:0]           perf_taken_cnt
`endif
);

   typedef enum logic {
      IDLE  = 1'b0,
      REDIR = 1'b1
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic                redirect_valid_q;
   logic [WID_DATA-1:0] redirect_pc_q;
   logic                redirect_valid_nxt;
   logic [WID_DATA-1:0] redirect_pc_nxt;
   logic                flush_nxt;
   logic                misalign_nxt;
   logic                illegal_nxt;

   logic                is_jalr;
   logic                is_jal;
   logic                is_br;
   logic                cond_take;
   logic                funct3_illegal;
   logic                take;
   logic                misaligned;
   logic [WID_DATA-1:0] pc_rel_target;
   logic [WID_DATA-1:0] jalr_target;
   logic [WID_DATA-1:0] target;

   // Control-transfer kind with priority jalr > jal > branch
   assign is_jalr = ex_is_jalr;
   assign is_jal  = ex_is_jal & ~ex_is_jalr;
   assign is_br   = ex_is_branch & ~ex_is_jal & ~ex_is_jalr;

   assign cmpop     = ~(ex_funct3[2] & ex_funct3[1]);
   assign link_data = ex_pc + WID_DATA'(4);

   always_comb begin
      cond_take      = 1'b0;
      funct3_illegal = 1'b0;
      case (ex_funct3)
         3'b000:         cond_take = br_eq;
         3'b001:         cond_take = ~br_eq;
         3'b100, 3'b110: cond_take = br_lt;
         3'b101, 3'b111: cond_take = ~br_lt;
         default:        funct3_illegal = 1'b1;
      endcase
   end

   assign take = ex_valid & (is_jalr | is_jal | (is_br & cond_take));

   // JALR targets are redirected as computed; only pc-relative targets are alignment checked
   assign pc_rel_target = ex_pc + ex_imm;
   assign jalr_target   = (rs1_data + ex_imm) & ~WID_DATA'(1);
   assign target        = is_jalr ? jalr_target : pc_rel_target;
   assign misaligned    = ~is_jalr & pc_rel_target[1];

   assign stall_ex = (state == REDIR);

   // Next-state and next registered outputs
   always_comb begin
      state_nxt          = state;
      redirect_valid_nxt = redirect_valid_q;
      redirect_pc_nxt    = redirect_pc_q;
      flush_nxt          = 1'b0;
      misalign_nxt       = 1'b0;
      illegal_nxt        = 1'b0;
      case (state)
         IDLE: begin
            illegal_nxt = ex_valid & is_br & funct3_illegal;
            if (take) begin
               if (misaligned) begin
                  misalign_nxt = 1'b1;
               end else begin
                  redirect_valid_nxt = 1'b1;
                  redirect_pc_nxt    = target;
                  flush_nxt          = 1'b1;
                  state_nxt          = REDIR;
               end
            end
         end
         REDIR: begin
            if (redir.redirect_ready) begin
               redirect_valid_nxt = 1'b0;
               state_nxt          = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= RESET_PC;
         flush_if_id      <= 1'b0;
         flush_id_ex      <= 1'b0;
         misalign_exc     <= 1'b0;
         illegal_br       <= 1'b0;
      end else begin
         state            <= state_nxt;
         redirect_valid_q <= redirect_valid_nxt;
         redirect_pc_q    <= redirect_pc_nxt;
         flush_if_id      <= flush_nxt;
         flush_id_ex      <= flush_nxt;
         misalign_exc     <= misalign_nxt;
         illegal_br       <= illegal_nxt;
      end
   end

   assign redir.redirect_valid = redirect_valid_q;
   assign redir.redirect_pc    = redirect_pc_q;

`ifdef BRU_PERF_CNT_EN
   // Branches evaluated and redirects accepted; both wrap naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_branch_cnt <= 32'd0;
         perf_taken_cnt  <= 32'd0;
      end else begin
         if ((state == IDLE) && ex_valid && is_br) begin
            perf_branch_cnt <= perf_branch_cnt + 32'd1;
         end
         if ((state == REDIR) && redir.redirect_ready) begin
            perf_taken_cnt <= perf_taken_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
